cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Hardware layer-loop controller for the CNN accelerator.
- Replaces the CPU's per-layer programming and polling loop:
  - holds a small per-layer descriptor table;
  - drives the accelerator's base-address and layer-config registers;
  - pulses layer_start and waits for layer_done;
  - advances the weight/param base addresses and moves to the next layer.
- Sits beside the accelerator's AHB register slave; its outputs mux onto the same register fields while busy=1.

Parameters:
- MAX_LAYERS, 8, descriptor table depth.
- W_LIDX, 3, clog2(MAX_LAYERS).
- TI, 16, input channels per kernel.
- TO, 16, parallel kernels.
- NB, 16, weights per buffer word.
- SETUP_CYC, 4, cycles config is held stable before layer_start.
- GAP_CYC, 128, idle cycles between layer_done and the next layer's setup.
- TIMEOUT_CYC, 0, max WAIT cycles per layer; 0 disables the watchdog.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous active-high reset.
- cfg_we  in  1  descriptor write strobe.
- cfg_idx  in  W_LIDX  descriptor index.
- cfg_act_shift  in  3  activation shift.
- cfg_bias_shift  in  5  bias shift.
- cfg_is_conv3x3  in  1  1 = 3x3 conv, 0 = 1x1.
- n_layers  in  4  number of layers to run (sampled at start).
- base_weight_init  in  20  first layer weight base.
- base_param_init  in  12  first layer param base.
- seq_start  in  1  start pulse.
- seq_abort  in  1  abort request.
- layer_done  in  1  accelerator done (level or pulse).
- base_address  out  32  {param[11:0], weight[19:0]}.
- layer_config  out  32  packed config (below).
- layer_start  out  1  one-cycle start pulse.
- busy  out  1  sequence active.
- cur_layer  out  4  index of the layer in progress.
- seq_done  out  1  one-cycle pulse after the last layer.
- seq_err  out  1  one-cycle pulse on bad start or timeout.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; descriptor table cleared to 0.
- Descriptor writes:
  - accepted only in IDLE, taking effect on the next cycle;
  - ignored while busy.
- layer_config[15:0] = {act[2:0], bias[4:0], idx[3:0], last, conv3x3, last, first}:
  - bit0 = first, bit1 = last, bit2 = conv3x3, bit3 = last;
  - bits[31:16] = 0;
  - first = (idx==0), last = (idx==n_layers-1).
- FSM states: IDLE, SETUP, START, WAIT, GAP, DONE.
- IDLE:
  - seq_start with 1<=n_layers<=MAX_LAYERS: latch n_layers and base inits, idx=0, go to SETUP, busy=1 from the next cycle.
  - seq_start with n_layers==0 or >MAX_LAYERS: seq_err pulse, stay in IDLE.
  - seq_start while busy: ignored.
- SETUP:
  - base_address and layer_config driven from the current idx and bases;
  - held SETUP_CYC cycles, then go to START.
- START: layer_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - a layer_done rising edge (registered previous value) completes the layer;
  - a level already high on entry does not count.
  - Bases then advance:
    - conv3x3: weight += TI*TO*9/NB (144); 1x1: weight += TO (16);
    - param += TO (16) in both cases;
    - additions wrap modulo 2^20 / 2^12.
  - Go to GAP.
  - Watchdog: if TIMEOUT_CYC>0 and the WAIT count reaches TIMEOUT_CYC, pulse seq_err and go to IDLE.
- GAP:
  - count GAP_CYC cycles;
  - if idx==n_layers-1, go to DONE; else idx++ and go to SETUP.
- DONE: seq_done=1 for one cycle, busy=0 on the next cycle, go to IDLE.
- base_address/layer_config hold their last values in IDLE.
- seq_abort in any non-IDLE state:
  - IDLE on the next cycle, layer_start forced 0;
  - no seq_done; abort has priority over layer_done in the same cycle.
- A layer_done edge coinciding with the START cycle is ignored.
- HRESET mid-sequence behaves as full reset, including clearing the descriptor table.

Decomposition:
- Shared package cnn_seq_pkg:
  - FSM state encoding;
  - config bit positions (CFG_FIRST=0, CFG_LAST=1, CFG_CONV3=2, CFG_LAST2=3, CFG_IDX_LSB=4, CFG_BIAS_LSB=8, CFG_ACT_LSB=13);
  - weight increment constants.
- One sub-module, cnn_seq_desc_table: MAX_LAYERS x 9-bit register file with a synchronous write port and a combinational read port.

Test Plan:
- Program 3 layers {1x1,b9,a7},{3x3,b17,a7},{3x3,b17,a7} with base inits 0/0, start n_layers=3, bench asserts layer_done 50 cycles after each layer_start:
  - layer_config = 0x0000E901, 0x0000F114, 0x0000F12E;
  - base_address = 0x00000000, 0x01000010, 0x020000A0;
  - exactly 3 layer_start pulses, seq_done once, busy falls one cycle later.
- layer_done held high throughout a WAIT entry -> no advance until it goes low then high again.
- seq_start with n_layers=0, then with n_layers=9 -> seq_err pulse each time, busy stays 0.
- seq_abort asserted in WAIT of layer 1, in the same cycle as a layer_done edge -> IDLE next cycle, no seq_done, cur_layer stays 1, base_address unchanged.
- TIMEOUT_CYC=100 with no layer_done -> seq_err pulses 100 cycles after layer_start, busy=0.
- cfg_we during busy with cfg_idx=1 -> table unchanged; rerunning the sequence reproduces the original layer_config values.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared FSM encoding, descriptor layout, config packing and weight stepping for the layer sequencer
package cnn_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_GAP, S_DONE} seq_state_e;
  typedef struct packed {
    logic [2:0] act;
    logic [4:0] bias;
    logic       conv3;
  } desc_t;
  localparam int CFG_FIRST    = 0;
  localparam int CFG_LAST     = 1;
  localparam int CFG_CONV3    = 2;
  localparam int CFG_LAST2    = 3;
  localparam int CFG_IDX_LSB  = 4;
  localparam int CFG_BIAS_LSB = 8;
  localparam int CFG_ACT_LSB  = 13;
  localparam int TI_DEF = 16;
  localparam int TO_DEF = 16;
  localparam int NB_DEF = 16;
  function automatic logic [19:0] weight_step(input logic conv3, input int ti, input int tk, input int nb);
    return conv3 ? 20'(ti * tk * 9 / nb) : 20'(tk);
  endfunction
  function automatic logic [15:0] pack_config(input desc_t d, input logic [3:0] idx, input logic first, input logic last);
    logic [15:0] w;
    w = '0;
    w[CFG_FIRST] = first;
    w[CFG_LAST] = last;
    w[CFG_CONV3] = d.conv3;
    w[CFG_LAST2] = last;
    w[CFG_IDX_LSB +: 4] = idx;
    w[CFG_BIAS_LSB +: 5] = d.bias;
    w[CFG_ACT_LSB +: 3] = d.act;
    return w;
  endfunction
endpackage

// File: rtl/cnn_seq_desc_table.sv
// cnn_seq_desc_table: per-layer descriptor register file with synchronous write and combinational read
module cnn_seq_desc_table
  import cnn_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int W_LIDX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [W_LIDX-1:0] widx,
  input  desc_t             wdata,
  input  logic [W_LIDX-1:0] ridx,
  output desc_t             rdata
);
  desc_t mem_q [MAX_LAYERS];
  desc_t mem_d [MAX_LAYERS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end
  always_ff @(posedge clk)
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata = mem_q[ridx];
endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: hardware layer loop that programs, starts and steps the CNN accelerator layer by layer
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int W_LIDX = 3,
  parameter int TI = TI_DEF,
  parameter int TO = TO_DEF,
  parameter int NB = NB_DEF,
  parameter int SETUP_CYC = 4,
  parameter int GAP_CYC = 128,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cfg_we,
  input  logic [W_LIDX-1:0] cfg_idx,
  input  logic [2:0]        cfg_act_shift,
  input  logic [4:0]        cfg_bias_shift,
  input  logic              cfg_is_conv3x3,
  input  logic [3:0]        n_layers,
  input  logic [19:0]       base_weight_init,
  input  logic [11:0]       base_param_init,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic              layer_done,
  output logic [31:0]       base_address,
  output logic [31:0]       layer_config,
  output logic              layer_start,
  output logic              busy,
  output logic [3:0]        cur_layer,
  output logic              seq_done,
  output logic              seq_err
);
  seq_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d, n_q, n_d;
  logic [19:0] weight_q, weight_d;
  logic [11:0] param_q, param_d;
  logic [31:0] cnt_q, cnt_d, base_q, base_d, cfg_q, cfg_d;
  logic        err_q, err_d, done_prev_q;
  logic        done_edge, last, start_ok;
  desc_t       desc, wdesc;
  assign wdesc = {cfg_act_shift, cfg_bias_shift, cfg_is_conv3x3};
  cnn_seq_desc_table #(.MAX_LAYERS(MAX_LAYERS), .W_LIDX(W_LIDX)) u_table (
    .clk(HCLK),
    .rst(HRESET),
    .we(cfg_we && state_q == S_IDLE),
    .widx(cfg_idx),
    .wdata(wdesc),
    .ridx(idx_q[W_LIDX-1:0]),
    .rdata(desc)
  );
  // only a fresh rising edge of layer_done counts, so a level left high from before WAIT is ignored
  assign done_edge = layer_done && !done_prev_q;
  assign last = idx_q == n_q - 4'd1;
  assign start_ok = n_layers != 4'd0 && {28'd0, n_layers} <= 32'(MAX_LAYERS);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    n_d = n_q;
    weight_d = weight_q;
    param_d = param_q;
    cnt_d = cnt_q + 32'd1;
    base_d = base_q;
    cfg_d = cfg_q;
    err_d = 1'b0;
    if (state_q != S_IDLE && seq_abort) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE:
          if (seq_start) begin
            err_d = !start_ok;
            if (start_ok) begin
              state_d = S_SETUP;
              idx_d = '0;
              n_d = n_layers;
              weight_d = base_weight_init;
              param_d = base_param_init;
              cnt_d = '0;
            end
          end
        S_SETUP: begin
          base_d = {param_q, weight_q};
          cfg_d = {16'd0, pack_config(desc, idx_q, idx_q == 4'd0, last)};
          if (cnt_q == 32'(SETUP_CYC - 1)) state_d = S_START;
        end
        // the watchdog counts from the layer_start cycle, so it fires TIMEOUT_CYC cycles after the pulse
        S_START: begin
          state_d = S_WAIT;
          cnt_d = 32'd1;
        end
        S_WAIT:
          if (done_edge) begin
            state_d = S_GAP;
            cnt_d = '0;
            weight_d = weight_q + weight_step(desc.conv3, TI, TO, NB);
            param_d = param_q + 12'(TO);
          end else if (TIMEOUT_CYC > 0 && cnt_q >= 32'(TIMEOUT_CYC - 1)) begin
            state_d = S_IDLE;
            err_d = 1'b1;
          end
        S_GAP:
          if (cnt_q == 32'(GAP_CYC - 1)) begin
            state_d = last ? S_DONE : S_SETUP;
            idx_d = last ? idx_q : idx_q + 4'd1;
            cnt_d = '0;
          end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      n_q <= '0;
      weight_q <= '0;
      param_q <= '0;
      cnt_q <= '0;
      base_q <= '0;
      cfg_q <= '0;
      err_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      n_q <= n_d;
      weight_q <= weight_d;
      param_q <= param_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      cfg_q <= cfg_d;
      err_q <= err_d;
      done_prev_q <= layer_done;
    end
  assign base_address = base_q;
  assign layer_config = cfg_q;
  assign layer_start = state_q == S_START && !seq_abort;
  assign busy = state_q != S_IDLE;
  assign cur_layer = idx_q;
  assign seq_done = state_q == S_DONE && !seq_abort;
  assign seq_err = err_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed and randomized checks of the layer sequencer against a reference model
module tb_cnn_layer_sequencer;
  localparam int TI = 16, TO = 16, NB = 16, SETUP = 4, GAP = 128, TMO = 100;
  logic HCLK = 0, HRESET = 1, cfg_we = 0, cfg_is_conv3x3 = 0, seq_start = 0, seq_abort = 0, layer_done = 0;
  logic [2:0] cfg_idx = 0, cfg_act_shift = 0;
  logic [4:0] cfg_bias_shift = 0;
  logic [3:0] n_layers = 0;
  logic [19:0] base_weight_init = 0;
  logic [11:0] base_param_init = 0;
  logic [31:0] base_address, layer_config, t_base, t_cfg;
  logic layer_start, busy, seq_done, seq_err, t_start, t_busy, t_done, t_err;
  logic [3:0] cur_layer, t_cur;
  int n_chk = 0, n_fail = 0, n_starts = 0, n_dones = 0, lat, s0, d0;
  int r_act [8], r_bias [8], r_conv [8];
  logic [31:0] got_cfg [8], got_base [8];

  cnn_layer_sequencer dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_act_shift(cfg_act_shift),
    .cfg_bias_shift(cfg_bias_shift), .cfg_is_conv3x3(cfg_is_conv3x3), .n_layers(n_layers),
    .base_weight_init(base_weight_init), .base_param_init(base_param_init), .seq_start(seq_start),
    .seq_abort(seq_abort), .layer_done(layer_done), .base_address(base_address), .layer_config(layer_config),
    .layer_start(layer_start), .busy(busy), .cur_layer(cur_layer), .seq_done(seq_done), .seq_err(seq_err));

  cnn_layer_sequencer #(.TIMEOUT_CYC(TMO)) dut_to (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_act_shift(cfg_act_shift),
    .cfg_bias_shift(cfg_bias_shift), .cfg_is_conv3x3(cfg_is_conv3x3), .n_layers(n_layers),
    .base_weight_init(base_weight_init), .base_param_init(base_param_init), .seq_start(seq_start),
    .seq_abort(seq_abort), .layer_done(layer_done), .base_address(t_base), .layer_config(t_cfg),
    .layer_start(t_start), .busy(t_busy), .cur_layer(t_cur), .seq_done(t_done), .seq_err(t_err));

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) begin
    if (layer_start) n_starts++;
    if (seq_done) n_dones++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cfg(input int i, input int n);
    return 32'(r_act[i] * 8192 + r_bias[i] * 256 + i * 16 + (i == n - 1 ? 10 : 0) + r_conv[i] * 4 + (i == 0 ? 1 : 0));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      r_act[i] = 0;
      r_bias[i] = 0;
      r_conv[i] = 0;
    end
  endtask

  task automatic write_desc(input int i, input int conv, input int bias, input int act, input bit accepted);
    @(negedge HCLK);
    cfg_we = 1;
    cfg_idx = 3'(i);
    cfg_is_conv3x3 = 1'(conv);
    cfg_bias_shift = 5'(bias);
    cfg_act_shift = 3'(act);
    @(negedge HCLK);
    cfg_we = 0;
    if (accepted) begin
      r_act[i] = act;
      r_bias[i] = bias;
      r_conv[i] = conv;
    end
  endtask

  task automatic start_seq(input int n, input logic [19:0] w0, input logic [11:0] p0);
    @(negedge HCLK);
    n_layers = 4'(n);
    base_weight_init = w0;
    base_param_init = p0;
    seq_start = 1;
    @(negedge HCLK);
    seq_start = 0;
  endtask

  task automatic wait_sig(input int which, input int lat0, output int l);
    l = lat0;
    while (l < 400 && !(which == 0 ? layer_start : which == 1 ? seq_done : seq_err)) begin
      @(negedge HCLK);
      l++;
    end
  endtask

  task automatic run_seq(input int n, input logic [19:0] w0, input logic [11:0] p0, input int dly);
    int l, st, w;
    st = n_starts;
    w = int'(w0);
    start_seq(n, w0, p0);
    chk("busy_after_start", 32'(busy), 1);
    l = 1;
    for (int k = 0; k < n; k++) begin
      wait_sig(0, l, l);
      chk("start_latency", l, k == 0 ? SETUP + 1 : GAP + SETUP + 1);
      got_cfg[k] = layer_config;
      got_base[k] = base_address;
      chk("layer_config", layer_config, exp_cfg(k, n));
      chk("base_address", base_address, {12'((int'(p0) + 16 * k) % 4096), 20'(w)});
      chk("cur_layer", 32'(cur_layer), 32'(k));
      @(negedge HCLK);
      chk("start_one_cycle", 32'(layer_start), 0);
      repeat (dly - 1) @(negedge HCLK);
      layer_done = 1;
      @(negedge HCLK);
      layer_done = 0;
      l = 1;
      w = (w + (r_conv[k] != 0 ? TI * TO * 9 / NB : TO)) % 1048576;
    end
    wait_sig(1, l, l);
    chk("done_latency", l, GAP + 1);
    chk("busy_at_done", 32'(busy), 1);
    @(negedge HCLK);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(seq_done), 0);
    chk("start_count", n_starts - st, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    clear_model();
    repeat (3) @(negedge HCLK);
    chk("rst_base", base_address, 0);
    chk("rst_cfg", layer_config, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(layer_start), 0);
    chk("rst_cur", 32'(cur_layer), 0);
    chk("rst_done_err", {30'd0, seq_done, seq_err}, 0);
    HRESET = 0;
    write_desc(0, 0, 9, 7, 1);
    write_desc(1, 1, 17, 7, 1);
    write_desc(2, 1, 17, 7, 1);
    d0 = n_dones;
    run_seq(3, 20'h0, 12'h0, 50);
    chk("cfg_l0", got_cfg[0], 32'h0000E901);
    chk("cfg_l1", got_cfg[1], 32'h0000F114);
    chk("cfg_l2", got_cfg[2], 32'h0000F12E);
    chk("base_l0", got_base[0], 32'h00000000);
    chk("base_l1", got_base[1], 32'h01000010);
    chk("base_l2", got_base[2], 32'h020000A0);
    chk("done_count", n_dones - d0, 1);
    // invalid layer counts
    start_seq(0, 20'h0, 12'h0);
    chk("err_n0", 32'(seq_err), 1);
    chk("busy_n0", 32'(busy), 0);
    @(negedge HCLK);
    chk("err_n0_pulse", 32'(seq_err), 0);
    start_seq(9, 20'h0, 12'h0);
    chk("err_n9", 32'(seq_err), 1);
    chk("busy_n9", 32'(busy), 0);
    @(negedge HCLK);
    chk("err_n9_pulse", 32'(seq_err), 0);
    // layer_done already high when WAIT is entered
    start_seq(1, 20'h0, 12'h0);
    wait_sig(0, 1, lat);
    chk("hold_start_latency", lat, SETUP + 1);
    layer_done = 1;
    repeat (30) @(negedge HCLK);
    chk("hold_busy", 32'(busy), 1);
    layer_done = 0;
    repeat (2) @(negedge HCLK);
    layer_done = 1;
    @(negedge HCLK);
    layer_done = 0;
    wait_sig(1, 1, lat);
    chk("hold_done_latency", lat, GAP + 1);
    @(negedge HCLK);
    chk("hold_busy_after", 32'(busy), 0);
    // abort in layer 1 coinciding with a done edge
    s0 = n_starts;
    d0 = n_dones;
    start_seq(3, 20'h0, 12'h0);
    wait_sig(0, 1, lat);
    repeat (10) @(negedge HCLK);
    layer_done = 1;
    @(negedge HCLK);
    layer_done = 0;
    wait_sig(0, 1, lat);
    chk("abort_l1_latency", lat, GAP + SETUP + 1);
    repeat (10) @(negedge HCLK);
    layer_done = 1;
    seq_abort = 1;
    @(negedge HCLK);
    layer_done = 0;
    seq_abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cur", 32'(cur_layer), 1);
    chk("abort_base", base_address, 32'h01000010);
    repeat (140) @(negedge HCLK);
    chk("abort_starts", n_starts - s0, 2);
    chk("abort_no_done", n_dones - d0, 0);
    // watchdog on the TIMEOUT_CYC=100 instance
    start_seq(1, 20'h0, 12'h0);
    wait_sig(0, 1, lat);
    repeat (99) @(negedge HCLK);
    chk("tmo_err_early", 32'(t_err), 0);
    chk("tmo_busy_early", 32'(t_busy), 1);
    @(negedge HCLK);
    chk("tmo_err", 32'(t_err), 1);
    chk("tmo_busy", 32'(t_busy), 0);
    chk("notmo_busy", 32'(busy), 1);
    @(negedge HCLK);
    chk("tmo_err_pulse", 32'(t_err), 0);
    seq_abort = 1;
    @(negedge HCLK);
    seq_abort = 0;
    chk("tmo_abort_idle", 32'(busy), 0);
    // descriptor write while busy must be ignored
    start_seq(3, 20'h0, 12'h0);
    write_desc(1, 0, 3, 2, 0);
    seq_abort = 1;
    @(negedge HCLK);
    seq_abort = 0;
    run_seq(3, 20'h0, 12'h0, 20);
    chk("rerun_cfg0", got_cfg[0], 32'h0000E901);
    chk("rerun_cfg1", got_cfg[1], 32'h0000F114);
    chk("rerun_cfg2", got_cfg[2], 32'h0000F12E);
    // reset mid-sequence clears everything including the table
    start_seq(3, 20'h0, 12'h0);
    repeat (20) @(negedge HCLK);
    HRESET = 1;
    @(negedge HCLK);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_base", base_address, 0);
    chk("rst2_cfg", layer_config, 0);
    chk("rst2_cur", 32'(cur_layer), 0);
    HRESET = 0;
    clear_model();
    run_seq(2, 20'hFFFF0, 12'hFF0, 10);
    chk("wrap_cfg0", got_cfg[0], 32'h00000001);
    chk("wrap_cfg1", got_cfg[1], 32'h0000001A);
    chk("wrap_base0", got_base[0], 32'hFF0FFFF0);
    chk("wrap_base1", got_base[1], 32'h00000000);
    // randomized tables, bases, layer counts and done delays
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++)
        write_desc(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), 1);
      run_seq(int'($urandom_range(1, 8)), 20'($urandom), 12'($urandom), int'($urandom_range(3, 60)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
